// File: rtl/fpto_int_seq_if.sv
// Stream/command bundle between the fpto_int sequencer and its neighbours.
// slave: the sequencer's view; master: the command/data source and converter model.
interface fpto_int_seq_if #(
  parameter int unsigned CNT_W = 16
);
  logic             cmd_vld;
  logic             cmd_rdy;
  logic             cmd_src_prec;
  logic             cmd_dst_prec;
  logic             cmd_pack;
  logic [CNT_W-1:0] cmd_len;

  logic             in_vld;
  logic             in_rdy;
  logic [31:0]      in_data;

  logic             cvt_inst_vld;
  logic             cvt_src_prec;
  logic             cvt_dst_prec;
  logic             cvt_src_pos;
  logic             cvt_dst_pos;
  logic [31:0]      cvt_in_reg;
  logic [31:0]      cvt_out_reg;
  logic             cvt_result_vld;

  logic             out_vld;
  logic             out_rdy;
  logic [31:0]      out_data;
  logic             out_last;

  logic             busy;
  logic             done;
  logic             err;

  modport slave (
    input  cmd_vld, cmd_src_prec, cmd_dst_prec, cmd_pack, cmd_len,
    output cmd_rdy,
    input  in_vld, in_data,
    output in_rdy,
    output cvt_inst_vld, cvt_src_prec, cvt_dst_prec, cvt_src_pos, cvt_dst_pos, cvt_in_reg,
    input  cvt_out_reg, cvt_result_vld,
    output out_vld, out_data, out_last,
    input  out_rdy,
    output busy, done, err
  );

  modport master (
    output cmd_vld, cmd_src_prec, cmd_dst_prec, cmd_pack, cmd_len,
    input  cmd_rdy,
    output in_vld, in_data,
    input  in_rdy,
    input  cvt_inst_vld, cvt_src_prec, cvt_dst_prec, cvt_src_pos, cvt_dst_pos, cvt_in_reg,
    output cvt_out_reg, cvt_result_vld,
    input  out_vld, out_data, out_last,
    output out_rdy,
    input  busy, done, err
  );
endinterface

// File: rtl/fpto_int_seq.sv
// Command-driven sequencer around the combinational fpto_int converter.
// Streams cmd_len input words through the converter, splitting FP16->INT32 words into two
// issues and merging packed FP32->INT16 results two per output word.
module fpto_int_seq #(
  parameter int unsigned CNT_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  fpto_int_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W:0]   OutOne = (CNT_W + 1)'(1);

  state_e           state_q, state_d;
  logic             rdy_en_q;
  logic             src_q, dst_q, pack_q;
  logic [CNT_W-1:0] len_q, in_cnt_q, iss_cnt_q;
  logic [CNT_W:0]   out_cnt_q, out_total_q, out_total_d;
  logic [31:0]      hold_q;
  logic             hold_vld_q, half_q;
  logic [15:0]      stage_q;
  logic             out_vld_q, out_last_q;
  logic [31:0]      out_data_q, res;
  logic             err_q;

  logic run, cmd_acc, in_rdy, in_acc, slot_free, issue, rel_hold;
  logic mode_split, word_last, stage_only, out_wr, out_hs;

  assign run        = (state_q == StRun);
  assign cmd_acc    = bus.cmd_vld && (state_q == StIdle) && rdy_en_q;
  assign mode_split = !src_q && dst_q;
  assign slot_free  = !out_vld_q || bus.out_rdy;
  assign issue      = run && hold_vld_q && slot_free;
  // An FP16->INT32 word stays held until its high half has been issued.
  assign rel_hold   = issue && (!mode_split || half_q);
  assign word_last  = (iss_cnt_q == len_q - CntOne);
  // Even packed word with a partner still to come: result goes to the stage, not the output.
  assign stage_only = pack_q && !iss_cnt_q[0] && !word_last;
  assign out_wr     = issue && !stage_only;
  assign out_hs     = out_vld_q && bus.out_rdy;
  assign in_rdy     = run && (in_cnt_q != len_q) && (!hold_vld_q || rel_hold);
  assign in_acc     = bus.in_vld && in_rdy;

  assign bus.cmd_rdy  = (state_q == StIdle) && rdy_en_q;
  assign bus.in_rdy   = in_rdy;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_data = out_data_q;
  assign bus.out_last = out_last_q;
  assign bus.busy     = run;
  assign bus.done     = (state_q == StDone);
  assign bus.err      = err_q;

  // Converter drive: everything zero unless an issue happens this cycle.
  always_comb begin
    bus.cvt_inst_vld = 1'b0;
    bus.cvt_src_prec = 1'b0;
    bus.cvt_dst_prec = 1'b0;
    bus.cvt_src_pos  = 1'b0;
    bus.cvt_dst_pos  = 1'b0;
    bus.cvt_in_reg   = 32'h0;
    if (issue) begin
      bus.cvt_inst_vld = 1'b1;
      bus.cvt_src_prec = src_q;
      bus.cvt_dst_prec = dst_q;
      bus.cvt_src_pos  = mode_split && half_q;
      bus.cvt_dst_pos  = pack_q && iss_cnt_q[0];
      bus.cvt_in_reg   = hold_q;
    end
  end

  // Output word formation from the converter result.
  always_comb begin
    res = bus.cvt_out_reg;
    if (pack_q) begin
      res = iss_cnt_q[0] ? (bus.cvt_out_reg | {16'h0, stage_q})
                         : {16'h0, bus.cvt_out_reg[15:0]};
    end else if (src_q && !dst_q) begin
      res = {16'h0, bus.cvt_out_reg[15:0]};
    end
  end

  // Number of output words the accepted command will produce.
  always_comb begin
    out_total_d = {1'b0, bus.cmd_len};
    if (!bus.cmd_src_prec && bus.cmd_dst_prec) begin
      out_total_d = {bus.cmd_len, 1'b0};
    end else if (bus.cmd_pack && bus.cmd_src_prec && !bus.cmd_dst_prec) begin
      out_total_d = ({1'b0, bus.cmd_len} + OutOne) >> 1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (cmd_acc) state_d = (bus.cmd_len == '0) ? StDone : StRun;
      StRun:   if (out_hs && out_last_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register plus the flag that holds cmd_rdy low until the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Command configuration and word/output counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q       <= 1'b0;
      dst_q       <= 1'b0;
      pack_q      <= 1'b0;
      len_q       <= '0;
      in_cnt_q    <= '0;
      iss_cnt_q   <= '0;
      out_cnt_q   <= '0;
      out_total_q <= '0;
    end else if (cmd_acc) begin
      src_q       <= bus.cmd_src_prec;
      dst_q       <= bus.cmd_dst_prec;
      pack_q      <= bus.cmd_pack && bus.cmd_src_prec && !bus.cmd_dst_prec;
      len_q       <= bus.cmd_len;
      in_cnt_q    <= '0;
      iss_cnt_q   <= '0;
      out_cnt_q   <= '0;
      out_total_q <= out_total_d;
    end else begin
      if (in_acc)   in_cnt_q  <= in_cnt_q + CntOne;
      if (rel_hold) iss_cnt_q <= iss_cnt_q + CntOne;
      if (out_wr)   out_cnt_q <= out_cnt_q + OutOne;
    end
  end

  // Input hold register and FP16 half selector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= 32'h0;
      hold_vld_q <= 1'b0;
      half_q     <= 1'b0;
    end else if (cmd_acc) begin
      hold_vld_q <= 1'b0;
      half_q     <= 1'b0;
    end else if (in_acc) begin
      hold_q     <= bus.in_data;
      hold_vld_q <= 1'b1;
      half_q     <= 1'b0;
    end else begin
      if (rel_hold) hold_vld_q <= 1'b0;
      if (issue && mode_split && !half_q) half_q <= 1'b1;
    end
  end

  // Staged low half of a packed FP32->INT16 pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= 16'h0;
    end else if (issue && stage_only) begin
      stage_q <= bus.cvt_out_reg[15:0];
    end
  end

  // Output register: loads on issue, holds while stalled, empties on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_data_q <= 32'h0;
      out_last_q <= 1'b0;
    end else if (out_wr) begin
      out_vld_q  <= 1'b1;
      out_data_q <= res;
      out_last_q <= ((out_cnt_q + OutOne) == out_total_q);
    end else if (out_hs) begin
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
    end
  end

  // Sticky error for an issue the converter did not acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (cmd_acc) begin
      err_q <= 1'b0;
    end else if (issue && !bus.cvt_result_vld) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpto_int_seq.sv
// Directed table-driven bench for fpto_int_seq with a behavioural fpto_int model.
module tb_fpto_int_seq;

  typedef struct {
    string            name;
    logic             src;
    logic             dst;
    logic             pack;
    int               len;
    logic [0:3][31:0] in_w;
    int               n_out;
    logic [0:3][31:0] exp_w;
    int               stall_lo;
    int               stall_hi;
    logic             exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic force_bad = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  vec_t vecs[9];

  fpto_int_seq_if #(.CNT_W(16)) ifc ();

  fpto_int_seq #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // ---------------- converter model ----------------
  function automatic longint to_int(logic sign, int e, longint m, int mbits);
    longint v;
    if (e < 0) return 0;
    if (e > 40) v = longint'(1) << 40;
    else if (e >= mbits) v = m << (e - mbits);
    else v = m >> (mbits - e);
    return sign ? -v : v;
  endfunction

  function automatic longint f32v(logic [31:0] f);
    return to_int(f[31], int'(f[30:23]) - 127, longint'({1'b1, f[22:0]}), 23);
  endfunction

  function automatic longint f16v(logic [15:0] h);
    return to_int(h[15], int'(h[14:10]) - 15, longint'({1'b1, h[9:0]}), 10);
  endfunction

  function automatic logic [31:0] sat32(longint v);
    longint hi, lo;
    hi = (longint'(1) << 31) - 1;
    lo = -(longint'(1) << 31);
    if (v > hi) return 32'h7FFF_FFFF;
    if (v < lo) return 32'h8000_0000;
    return v[31:0];
  endfunction

  function automatic logic [15:0] sat16(longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  always_comb begin
    ifc.cvt_out_reg    = 32'h0;
    ifc.cvt_result_vld = 1'b0;
    if (ifc.cvt_inst_vld) begin
      ifc.cvt_result_vld = !force_bad;
      if (ifc.cvt_src_prec) begin
        if (ifc.cvt_dst_prec) ifc.cvt_out_reg = sat32(f32v(ifc.cvt_in_reg));
        else if (ifc.cvt_dst_pos) ifc.cvt_out_reg = {sat16(f32v(ifc.cvt_in_reg)), 16'h0};
        else ifc.cvt_out_reg = {16'h0, sat16(f32v(ifc.cvt_in_reg))};
      end else if (ifc.cvt_dst_prec) begin
        ifc.cvt_out_reg = sat32(f16v(ifc.cvt_src_pos ? ifc.cvt_in_reg[31:16]
                                                     : ifc.cvt_in_reg[15:0]));
      end else begin
        ifc.cvt_out_reg = {sat16(f16v(ifc.cvt_in_reg[31:16])), sat16(f16v(ifc.cvt_in_reg[15:0]))};
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(string name, logic src, logic dst, logic pack, int len,
                              logic [0:3][31:0] in_w, int n_out, logic [0:3][31:0] exp_w,
                              int slo, int shi, logic exp_err);
    vec_t v;
    v.name = name; v.src = src; v.dst = dst; v.pack = pack; v.len = len;
    v.in_w = in_w; v.n_out = n_out; v.exp_w = exp_w;
    v.stall_lo = slo; v.stall_hi = shi; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic send_cmd(string name, logic src, logic dst, logic pack, int len);
    int k = 0;
    while (ifc.cmd_rdy !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk($sformatf("%s/cmd_rdy_wait", name), 64'(ifc.cmd_rdy), 64'd1);
    ifc.cmd_src_prec = src;
    ifc.cmd_dst_prec = dst;
    ifc.cmd_pack     = pack;
    ifc.cmd_len      = 16'(len);
    ifc.cmd_vld      = 1'b1;
    tick();
    ifc.cmd_vld      = 1'b0;
  endtask

  task automatic run_vec(vec_t v);
    int ii = 0, oi = 0, iss = 0, widx;
    int t_in0 = -1, t_out0 = -1, t_last = -1, t_done = -1;
    bit got_done = 0, saw_drop = 0, leak = 0, prev_stall = 0, prev_last = 0;
    bit split, rpack;
    logic [31:0] prev_data = 32'h0;
    logic [31:0] exp_in;
    split = !v.src && v.dst;
    rpack = v.pack && v.src && !v.dst;
    force_bad = v.exp_err;
    send_cmd(v.name, v.src, v.dst, v.pack, v.len);
    for (int cyc = 0; cyc < 200; cyc++) begin
      // Words beyond cmd_len are junk beats that must be ignored.
      ifc.in_vld  = 1'b1;
      ifc.in_data = (ii < v.len && ii < 4) ? v.in_w[ii] : 32'hDEAD_BEEF;
      ifc.out_rdy = !(cyc >= v.stall_lo && cyc <= v.stall_hi);
      @(negedge clk);
      if (cyc == 0) chk($sformatf("%s/busy_first", v.name), 64'(ifc.busy), 64'(v.len > 0));
      if (prev_stall) begin
        chk($sformatf("%s/hold_stable", v.name), {ifc.out_vld, ifc.out_last, ifc.out_data},
            {1'b1, prev_last, prev_data});
      end
      if (ifc.cvt_inst_vld) begin
        widx   = split ? iss / 2 : iss;
        exp_in = (widx < 4) ? v.in_w[widx] : 32'hFFFF_FFFF;
        chk($sformatf("%s/issue[%0d]", v.name, iss),
            {ifc.cvt_src_prec, ifc.cvt_dst_prec, ifc.cvt_src_pos, ifc.cvt_dst_pos, ifc.cvt_in_reg},
            {v.src, v.dst, split && (iss % 2 == 1), rpack && (widx % 2 == 1), exp_in});
        iss++;
      end else if (ifc.cvt_src_prec || ifc.cvt_dst_prec || ifc.cvt_src_pos || ifc.cvt_dst_pos ||
                   ifc.cvt_in_reg != 32'h0) begin
        leak = 1;
      end
      if (ifc.in_vld && ifc.in_rdy) begin
        if (ii == 0) t_in0 = cyc;
        ii++;
      end else if (ii < v.len && !ifc.out_rdy) begin
        saw_drop = 1;
      end
      if (ifc.out_vld && t_out0 < 0) t_out0 = cyc;
      if (ifc.out_vld && ifc.out_rdy) begin
        if (oi < v.n_out && oi < 4) begin
          chk($sformatf("%s/out[%0d]", v.name, oi), {ifc.out_last, ifc.out_data},
              {oi == v.n_out - 1, v.exp_w[oi]});
        end else begin
          chk($sformatf("%s/extra_out", v.name), 64'(oi), 64'(v.n_out));
        end
        if (ifc.out_last) t_last = cyc;
        oi++;
      end
      if (ifc.done) begin
        t_done = cyc;
        got_done = 1;
        chk($sformatf("%s/busy_at_done", v.name), 64'(ifc.busy), 64'd0);
        break;
      end
      prev_stall = ifc.out_vld && !ifc.out_rdy;
      prev_last  = ifc.out_last;
      prev_data  = ifc.out_data;
      @(posedge clk);
      #1;
    end
    ifc.in_vld  = 1'b0;
    ifc.out_rdy = 1'b1;
    chk($sformatf("%s/done_seen", v.name), 64'(got_done), 64'd1);
    chk($sformatf("%s/out_count", v.name), 64'(oi), 64'(v.n_out));
    chk($sformatf("%s/in_count", v.name), 64'(ii), 64'(v.len));
    chk($sformatf("%s/done_time", v.name), 64'(t_done), 64'((v.len == 0) ? 0 : t_last + 1));
    chk($sformatf("%s/cvt_idle_zero", v.name), 64'(leak), 64'd0);
    chk($sformatf("%s/err", v.name), 64'(ifc.err), 64'(v.exp_err));
    if (v.len > 0 && !rpack) chk($sformatf("%s/latency", v.name), 64'(t_out0 - t_in0), 64'd2);
    if (v.stall_hi >= 0) chk($sformatf("%s/in_rdy_drop", v.name), 64'(saw_drop), 64'd1);
    tick();
    chk($sformatf("%s/after_done", v.name), {ifc.done, ifc.cmd_rdy}, {1'b0, 1'b1});
    force_bad = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ifc.cmd_vld = 1'b0; ifc.cmd_src_prec = 1'b0; ifc.cmd_dst_prec = 1'b0;
    ifc.cmd_pack = 1'b0; ifc.cmd_len = 16'h0;
    ifc.in_vld = 1'b0; ifc.in_data = 32'h0; ifc.out_rdy = 1'b1;

    vecs[0] = mk("fp32_i32", 1, 1, 0, 3, {32'h3F800000, 32'hBF800000, 32'h40400000, 32'h0},
                 3, {32'h00000001, 32'hFFFFFFFF, 32'h00000003, 32'h0}, -1, -1, 0);
    vecs[1] = mk("fp16_i32", 0, 1, 0, 1, {32'h40003C00, 32'h0, 32'h0, 32'h0},
                 2, {32'h00000001, 32'h00000002, 32'h0, 32'h0}, -1, -1, 0);
    vecs[2] = mk("fp32_i16_pack", 1, 0, 1, 3, {32'h3F800000, 32'h40000000, 32'h41200000, 32'h0},
                 2, {32'h00020001, 32'h0000000A, 32'h0, 32'h0}, -1, -1, 0);
    vecs[3] = mk("fp16x2_i16_stall", 0, 0, 0, 4, {4{32'hC600C500}}, 4, {4{32'hFFFAFFFB}},
                 3, 7, 0);
    vecs[4] = mk("len0", 1, 1, 0, 0, {4{32'h0}}, 0, {4{32'h0}}, -1, -1, 0);
    vecs[5] = mk("fp32_i16_unpk", 1, 0, 0, 2, {32'h40A00000, 32'hC0000000, 32'h0, 32'h0},
                 2, {32'h00000005, 32'h0000FFFE, 32'h0, 32'h0}, -1, -1, 0);
    vecs[6] = mk("fp16_i32_stall", 0, 1, 0, 2, {32'hBC003C00, 32'h44004200, 32'h0, 32'h0},
                 4, {32'h00000001, 32'hFFFFFFFF, 32'h00000003, 32'h00000004}, 2, 3, 0);
    vecs[7] = mk("pack_even", 1, 0, 1, 2, {32'hBF800000, 32'h40400000, 32'h0, 32'h0},
                 1, {32'h0003FFFF, 32'h0, 32'h0, 32'h0}, -1, -1, 0);
    vecs[8] = mk("pack_ignored", 0, 0, 1, 1, {32'h3C00C600, 32'h0, 32'h0, 32'h0},
                 1, {32'h0001FFFA, 32'h0, 32'h0, 32'h0}, -1, -1, 0);

    // Power-on reset: every output low, including cmd_rdy.
    #1 rst_n = 1'b0;
    #2;
    chk("reset/ctl", {ifc.cmd_rdy, ifc.in_rdy, ifc.cvt_inst_vld, ifc.out_vld, ifc.out_last,
                      ifc.busy, ifc.done, ifc.err}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
    chk("reset/cmd_rdy_up", 64'(ifc.cmd_rdy), 64'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a stalled L=8 command.
    send_cmd("midreset", 1, 1, 0, 8);
    ifc.in_vld  = 1'b1;
    ifc.in_data = 32'h3F800000;
    ifc.out_rdy = 1'b0;
    repeat (4) tick();
    chk("midreset/pre", {ifc.busy, ifc.out_vld, ifc.out_data}, {1'b1, 1'b1, 32'h1});
    #3 rst_n = 1'b0;
    #1;
    chk("midreset/ctl", {ifc.cmd_rdy, ifc.in_rdy, ifc.cvt_inst_vld, ifc.cvt_src_prec,
                         ifc.cvt_dst_prec, ifc.cvt_src_pos, ifc.cvt_dst_pos, ifc.out_vld,
                         ifc.out_last, ifc.busy, ifc.done, ifc.err}, 64'd0);
    chk("midreset/data", {ifc.out_data, ifc.cvt_in_reg}, 64'd0);
    ifc.in_vld  = 1'b0;
    ifc.out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();
    chk("midreset/after", {ifc.cmd_rdy, ifc.out_vld, ifc.busy}, {1'b1, 1'b0, 1'b0});

    run_vec(mk("post_reset", 1, 1, 0, 1, {32'h3F800000, 32'h0, 32'h0, 32'h0},
               1, {32'h00000001, 32'h0, 32'h0, 32'h0}, -1, -1, 0));
    run_vec(mk("err_forced", 1, 1, 0, 1, {32'h3F800000, 32'h0, 32'h0, 32'h0},
               1, {32'h00000001, 32'h0, 32'h0, 32'h0}, -1, -1, 1));
    // A fresh command clears the sticky error.
    run_vec(mk("err_cleared", 1, 1, 0, 1, {32'h40400000, 32'h0, 32'h0, 32'h0},
               1, {32'h00000003, 32'h0, 32'h0, 32'h0}, -1, -1, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
